// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: segment patterns {a,b,c,d,e,f,g}, a = bit 6.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_OOR   = 7'b1100011;

  // Non-BCD nibbles A..F all render the same out-of-range glyph.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, SEG_OOR,    SEG_OOR,
    SEG_OOR,    SEG_OOR,    SEG_OOR,    SEG_OOR
  };

  function automatic seg_t seg_lookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble -> segment pattern, with a blank override for suppressed digits.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_lookup(nibble);
    if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment scanner: prescaler, wrapping digit index, shadow/display
// registers for tear-free updates, leading-zero suppression and registered pin outputs.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DIV         = 65536,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                                             CP,
  input  logic                                             nCR,
  input  logic                                             EN,
  input  logic                                             LOAD,
  input  logic [4*DIGITS-1:0]                              DATA,
  output logic [(($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1)-1:0] SEL,
  output logic [DIGITS-1:0]                                DIG,
  output logic [6:0]                                       SEG,
  output logic                                             FRAME
);

  localparam int IW = ($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       presc_reg;
  logic [IW-1:0]       index_reg;
  logic [IW-1:0]       index_next;
  logic [4*DIGITS-1:0] shadow_reg;
  logic [4*DIGITS-1:0] display_reg;
  logic [DIGITS-1:0]   dig_reg;
  logic [6:0]          seg_reg;
  logic                frame_reg;

  logic                tick;
  logic                frame_start;
  logic [4*DIGITS-1:0] src_word;
  logic [3:0]          nibbles [DIGITS];
  logic [DIGITS:1]     zero_above;
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   dig_onehot;
  logic [3:0]          sel_nibble;
  logic                sel_blank;
  logic [6:0]          seg_next;

  assign tick        = EN && (presc_reg == PRESC_LAST);
  assign index_next  = (index_reg == INDEX_LAST) ? '0 : index_reg + IW'(1);
  assign frame_start = tick && (index_reg == INDEX_LAST);

  // At a frame start the display register is loading this very edge, so decode
  // from the shadow value it is about to take.
  assign src_word = frame_start ? shadow_reg : display_reg;

  assign zero_above[DIGITS] = 1'b1;
  assign blank_mask[0]      = 1'b0;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nibbles[gi]    = src_word[4*gi +: 4];
    assign dig_onehot[gi] = (index_next == IW'(gi));
    if (gi > 0) begin : g_lz
      assign zero_above[gi] = (src_word[4*gi +: 4] == 4'd0) && zero_above[gi+1];
      assign blank_mask[gi] = (LZ_SUPPRESS != 0) && zero_above[gi];
    end
  end

  assign sel_nibble = nibbles[index_next];
  assign sel_blank  = blank_mask[index_next];

  seg7_decode u_decode (
    .nibble (sel_nibble),
    .blank  (sel_blank),
    .seg    (seg_next)
  );

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      presc_reg <= '0;
      index_reg <= INDEX_LAST;
    end else if (!EN) begin
      presc_reg <= '0;
      index_reg <= INDEX_LAST;
    end else if (tick) begin
      presc_reg <= '0;
      index_reg <= index_next;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      shadow_reg  <= '0;
      display_reg <= '0;
    end else begin
      if (LOAD) begin
        shadow_reg <= DATA;
      end
      if (frame_start) begin
        display_reg <= shadow_reg;
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      dig_reg   <= '0;
      seg_reg   <= SEG_BLANK;
      frame_reg <= 1'b0;
    end else if (!EN) begin
      dig_reg   <= '0;
      seg_reg   <= SEG_BLANK;
      frame_reg <= 1'b0;
    end else begin
      frame_reg <= frame_start;
      if (tick) begin
        dig_reg <= dig_onehot;
        seg_reg <= seg_next;
      end
    end
  end

  assign SEL   = index_reg;
  assign DIG   = dig_reg;
  assign SEG   = seg_reg;
  assign FRAME = frame_reg;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed vector bench for seg7_scan_mux (DIGITS=4, DIV=4), one instance with and one
// without leading-zero suppression, driven from a shared stimulus table.
module tb_seg7_scan_mux;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] SX = 7'b1100011;
  localparam logic [6:0] SB = 7'b0000000;

  logic        CP;
  logic        nCR;
  logic        EN;
  logic        LOAD;
  logic [15:0] DATA;
  logic [1:0]  sel_lz, sel_nz;
  logic [3:0]  dig_lz, dig_nz;
  logic [6:0]  seg_lz, seg_nz;
  logic        frame_lz, frame_nz;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [1:0]  sel;
    logic [3:0]  dig;
    logic [6:0]  seg_lz;
    logic [6:0]  seg_nz;
    logic        frame;
  } vec_t;

  vec_t vq[$];

  seg7_scan_mux #(.DIGITS(4), .DIV(4), .LZ_SUPPRESS(1)) u_lz (
    .CP(CP), .nCR(nCR), .EN(EN), .LOAD(LOAD), .DATA(DATA),
    .SEL(sel_lz), .DIG(dig_lz), .SEG(seg_lz), .FRAME(frame_lz)
  );

  seg7_scan_mux #(.DIGITS(4), .DIV(4), .LZ_SUPPRESS(0)) u_nz (
    .CP(CP), .nCR(nCR), .EN(EN), .LOAD(LOAD), .DATA(DATA),
    .SEL(sel_nz), .DIG(dig_nz), .SEG(seg_nz), .FRAME(frame_nz)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input int cyc, input logic en, input logic load, input logic [15:0] data,
                     input logic [1:0] sel, input logic [3:0] dig, input logic [6:0] slz,
                     input logic [6:0] snz, input logic frame);
    vec_t v;
    v.cyc = cyc; v.en = en; v.load = load; v.data = data;
    v.sel = sel; v.dig = dig; v.seg_lz = slz; v.seg_nz = snz; v.frame = frame;
    vq.push_back(v);
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [1:0] sel, input logic [3:0] dig,
                         input logic [6:0] slz, input logic [6:0] snz, input logic frame);
    chk({tag, "_sel"},   idx, 16'(sel_lz),   16'(sel));
    chk({tag, "_dig"},   idx, 16'(dig_lz),   16'(dig));
    chk({tag, "_frame"}, idx, 16'(frame_lz), 16'(frame));
    chk({tag, "_seglz"}, idx, 16'(seg_lz),   16'(slz));
    chk({tag, "_dignz"}, idx, 16'(dig_nz),   16'(dig));
    chk({tag, "_segnz"}, idx, 16'(seg_nz),   16'(snz));
  endtask

  initial begin
    nCR = 1'b0; EN = 1'b0; LOAD = 1'b0; DATA = 16'h0;

    // cyc, en, load, data, sel, dig, seg_lz, seg_nz, frame
    add(1, 1, 1, 16'h1234, 2'd3, 4'b0000, SB, SB, 0);
    add(3, 1, 0, 16'h0,    2'd0, 4'b0001, S4, S4, 1);
    add(1, 1, 0, 16'h0,    2'd0, 4'b0001, S4, S4, 0);
    add(3, 1, 0, 16'h0,    2'd1, 4'b0010, S3, S3, 0);
    add(4, 1, 0, 16'h0,    2'd2, 4'b0100, S2, S2, 0);
    add(4, 1, 0, 16'h0,    2'd3, 4'b1000, S1, S1, 0);
    add(4, 1, 0, 16'h0,    2'd0, 4'b0001, S4, S4, 1);
    add(1, 1, 1, 16'h0070, 2'd0, 4'b0001, S4, S4, 0);
    add(3, 1, 0, 16'h0,    2'd1, 4'b0010, S3, S3, 0);
    add(4, 1, 0, 16'h0,    2'd2, 4'b0100, S2, S2, 0);
    add(4, 1, 0, 16'h0,    2'd3, 4'b1000, S1, S1, 0);
    add(4, 1, 0, 16'h0,    2'd0, 4'b0001, S0, S0, 1);
    add(4, 1, 0, 16'h0,    2'd1, 4'b0010, S7, S7, 0);
    add(4, 1, 0, 16'h0,    2'd2, 4'b0100, SB, S0, 0);
    add(4, 1, 0, 16'h0,    2'd3, 4'b1000, SB, S0, 0);
    add(1, 1, 1, 16'h0000, 2'd3, 4'b1000, SB, S0, 0);
    add(3, 1, 0, 16'h0,    2'd0, 4'b0001, S0, S0, 1);
    add(4, 1, 0, 16'h0,    2'd1, 4'b0010, SB, S0, 0);
    add(4, 1, 0, 16'h0,    2'd2, 4'b0100, SB, S0, 0);
    add(4, 1, 0, 16'h0,    2'd3, 4'b1000, SB, S0, 0);
    add(1, 1, 1, 16'h0C00, 2'd3, 4'b1000, SB, S0, 0);
    add(3, 1, 0, 16'h0,    2'd0, 4'b0001, S0, S0, 1);
    add(4, 1, 0, 16'h0,    2'd1, 4'b0010, S0, S0, 0);
    add(4, 1, 0, 16'h0,    2'd2, 4'b0100, SX, SX, 0);
    add(4, 1, 0, 16'h0,    2'd3, 4'b1000, SB, S0, 0);
    add(3, 1, 0, 16'h0,    2'd3, 4'b1000, SB, S0, 0);
    add(1, 1, 1, 16'h5555, 2'd0, 4'b0001, S0, S0, 1);
    add(4, 1, 0, 16'h0,    2'd1, 4'b0010, S0, S0, 0);
    add(4, 1, 0, 16'h0,    2'd2, 4'b0100, SX, SX, 0);
    add(4, 1, 0, 16'h0,    2'd3, 4'b1000, SB, S0, 0);
    add(4, 1, 0, 16'h0,    2'd0, 4'b0001, S5, S5, 1);
    add(4, 1, 0, 16'h0,    2'd1, 4'b0010, S5, S5, 0);
    add(1, 1, 0, 16'h0,    2'd1, 4'b0010, S5, S5, 0);
    add(1, 0, 0, 16'h0,    2'd3, 4'b0000, SB, SB, 0);
    add(3, 0, 0, 16'h0,    2'd3, 4'b0000, SB, SB, 0);
    add(1, 1, 0, 16'h0,    2'd3, 4'b0000, SB, SB, 0);
    add(2, 1, 0, 16'h0,    2'd3, 4'b0000, SB, SB, 0);
    add(1, 1, 0, 16'h0,    2'd0, 4'b0001, S5, S5, 1);
    add(4, 1, 0, 16'h0,    2'd1, 4'b0010, S5, S5, 0);

    #22;
    chk_all("reset", -1, 2'd3, 4'b0000, SB, SB, 0);
    @(posedge CP);
    #1;
    nCR = 1'b1;

    foreach (vq[i]) begin
      EN   = vq[i].en;
      LOAD = vq[i].load;
      DATA = vq[i].data;
      step(vq[i].cyc);
      $display("vec %0d: en=%0b load=%0b sel=%0d dig=%b seg_lz=%b seg_nz=%b frame=%0b",
               i, vq[i].en, vq[i].load, sel_lz, dig_lz, seg_lz, seg_nz, frame_lz);
      chk_all("vec", i, vq[i].sel, vq[i].dig, vq[i].seg_lz, vq[i].seg_nz, vq[i].frame);
    end
    LOAD = 1'b0;

    // Asynchronous reset mid-digit: outputs must clear before any clock edge.
    #3;
    nCR = 1'b0;
    #1;
    $display("async reset: sel=%0d dig=%b seg_lz=%b seg_nz=%b frame=%0b",
             sel_lz, dig_lz, seg_lz, seg_nz, frame_lz);
    chk_all("arst", 0, 2'd3, 4'b0000, SB, SB, 0);
    step(2);
    chk_all("arst", 1, 2'd3, 4'b0000, SB, SB, 0);
    nCR = 1'b1;
    step(3);
    $display("post reset +3: sel=%0d dig=%b", sel_lz, dig_lz);
    chk_all("rst_rel", 0, 2'd3, 4'b0000, SB, SB, 0);
    step(1);
    $display("post reset +4: sel=%0d dig=%b seg_nz=%b frame=%0b", sel_lz, dig_lz, seg_nz, frame_lz);
    chk_all("rst_rel", 1, 2'd0, 4'b0001, S0, S0, 1);
    step(4);
    $display("post reset +8: sel=%0d dig=%b seg_lz=%b seg_nz=%b", sel_lz, dig_lz, seg_lz, seg_nz);
    chk_all("rst_rel", 2, 2'd1, 4'b0010, SB, S0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
